// File: rtl/dr_seq_pkg.sv
// Shared types and constants for the DataRegister load sequencer:
// FSM states, operand width codes, DataRegister function selects and
// a helper that maps a width code to its byte count.
package dr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } seq_state_t;

    // Operand width codes as presented on the Width input.
    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;
    localparam logic [1:0] W_RSVD = 2'b11;

    // DataRegister function selects.
    localparam logic [1:0] FS_SEXT = 2'b00;
    localparam logic [1:0] FS_ZEXT = 2'b01;
    localparam logic [1:0] FS_SHL  = 2'b10;
    localparam logic [1:0] FS_SHR  = 2'b11;

    // Number of memory bytes that make up an operand of the given width.
    function automatic logic [2:0] byteCount(input logic [1:0] width);
        case (width)
            W_BYTE:  return 3'd1;
            W_HALF:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Load select for the first byte of a byte/halfword operand.
    function automatic logic [1:0] extFunSel(input logic signExt);
        return signExt ? FS_SEXT : FS_ZEXT;
    endfunction

endpackage

// File: rtl/dr_seq_timeout.sv
// Wait counter guarding each memory byte. Loading arms it with LIMIT
// cycles; every idle tick counts down, and o_expire flags the tick on
// which the last allowed cycle is consumed. Clear parks it at zero.
module dr_seq_timeout #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_tick,
    output logic o_expire
);

    localparam logic [7:0] LIMIT_C = 8'(LIMIT);

    logic [7:0] r_count;

    // Down-counter: clear wins over load, load wins over a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= LIMIT_C;
        end else if (i_tick && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_expire = i_tick && !i_load && !i_clear && (r_count == 8'd1);

endmodule

// File: rtl/dr_load_sequencer.sv
// Sequences byte reads from a byte-wide memory into the 8-bit-input
// DataRegister to build byte, halfword or word operands, sign- or
// zero-extended. The DataRegister I input is wired to MemData outside
// this block; DR_E follows MemReady so the register captures each byte
// on the same edge the sequencer advances.
// Optional build macro DRSEQ_LITTLE_ENDIAN_EN selects little-endian
// byte ordering; without it operands are assembled big-endian.
module dr_load_sequencer
    import dr_seq_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [1:0]        Width,
    input  logic              SignExt,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic              MemReady,
    output logic              MemRead,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              DR_E,
    output logic [1:0]        DR_FunSel,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

    seq_state_t        r_state;
    logic              r_memRead;
    logic [ADDR_W-1:0] r_memAddr;
    logic [1:0]        r_funSel;
    logic [1:0]        r_laterFs;
    logic              r_descend;
    logic [2:0]        r_bytesLeft;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic [ADDR_W-1:0] w_firstAddr;
    logic [ADDR_W-1:0] w_nextAddr;
    logic [1:0]        w_firstFs;
    logic [1:0]        w_laterFs;
    logic              w_descend;
    logic              w_accept;
    logic              w_timerLoad;
    logic              w_timerTick;
    logic              w_timerClear;
    logic              w_expire;

    assign w_accept = (r_state == IDLE) && Start && (Width != W_RSVD);

    // Decode the incoming request into first address, load selects and
    // address direction so the FSM only has to latch them.
    always_comb begin
        w_firstAddr = BaseAddr;
        w_firstFs   = (Width == W_WORD) ? FS_ZEXT : extFunSel(SignExt);
        w_laterFs   = FS_SHL;
        w_descend   = 1'b0;
`ifdef DRSEQ_LITTLE_ENDIAN_EN
        if (Width == W_WORD) begin
            w_firstFs = FS_SHR;
            w_laterFs = FS_SHR;
        end else begin
            w_firstAddr = BaseAddr + ADDR_W'(byteCount(Width) - 3'd1);
            w_descend   = 1'b1;
        end
`endif
    end

    assign w_nextAddr = r_descend ? (r_memAddr - ADDR_W'(1)) : (r_memAddr + ADDR_W'(1));

    assign w_timerLoad  = w_accept || ((r_state == REQ) && MemReady);
    assign w_timerTick  = (r_state == REQ) && !MemReady;
    assign w_timerClear = (r_state == DONE) || (r_state == ERR);

    dr_seq_timeout #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk      (Clock),
        .rst_n    (Reset_n),
        .i_clear  (w_timerClear),
        .i_load   (w_timerLoad),
        .i_tick   (w_timerTick),
        .o_expire (w_expire)
    );

    // Load sequencing FSM with registered memory and status outputs.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_memRead   <= 1'b0;
            r_memAddr   <= '0;
            r_funSel    <= FS_SEXT;
            r_laterFs   <= FS_SHL;
            r_descend   <= 1'b0;
            r_bytesLeft <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_busy <= 1'b1;
                        if (Width == W_RSVD) begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                        end else begin
                            r_state     <= REQ;
                            r_memRead   <= 1'b1;
                            r_memAddr   <= w_firstAddr;
                            r_funSel    <= w_firstFs;
                            r_laterFs   <= w_laterFs;
                            r_descend   <= w_descend;
                            r_bytesLeft <= byteCount(Width);
                        end
                    end
                end
                REQ: begin
                    if (MemReady) begin
                        if (r_bytesLeft == 3'd1) begin
                            r_state     <= DONE;
                            r_memRead   <= 1'b0;
                            r_funSel    <= FS_SEXT;
                            r_bytesLeft <= 3'd0;
                            r_done      <= 1'b1;
                        end else begin
                            r_bytesLeft <= r_bytesLeft - 3'd1;
                            r_memAddr   <= w_nextAddr;
                            r_funSel    <= r_laterFs;
                        end
                    end else if (w_expire) begin
                        r_state     <= ERR;
                        r_memRead   <= 1'b0;
                        r_funSel    <= FS_SEXT;
                        r_bytesLeft <= 3'd0;
                        r_error     <= 1'b1;
                    end
                end
                DONE, ERR: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign MemRead   = r_memRead;
    assign MemAddr   = r_memAddr;
    assign DR_E      = r_memRead & MemReady;
    assign DR_FunSel = r_funSel;
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Error     = r_error;

endmodule

// File: tb/tb_dr_load_sequencer.sv
// Scoreboard bench for dr_load_sequencer. Stimulus pushes the expected
// byte loads, Done and Error events; a monitor pops and compares them
// whenever the DUT enables the DataRegister or pulses Done/Error.
// A behavioural DataRegister and byte memory supply the operand value.
module tb_dr_load_sequencer;
    import dr_seq_pkg::*;

    logic        Clock;
    logic        Reset_n;
    logic        Start;
    logic [1:0]  Width;
    logic        SignExt;
    logic [15:0] BaseAddr;
    logic        MemReady;
    logic        MemRead;
    logic [15:0] MemAddr;
    logic        DR_E;
    logic [1:0]  DR_FunSel;
    logic        Busy;
    logic        Done;
    logic        Error;

    logic [7:0]  mem [0:65535];
    logic [7:0]  MemData;
    logic [31:0] drOut;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int readCycles = 0;
    int stallCfg = 0;
    int reqRun = 0;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [1:0]  fs;
        logic [31:0] value;
        int          cycle;
    } expEvent_t;

    expEvent_t expQ[$];

`ifdef DRSEQ_LITTLE_ENDIAN_EN
    localparam logic [1:0]  WORD_FS0  = FS_SHR;
    localparam logic [1:0]  WORD_FSN  = FS_SHR;
    localparam logic [31:0] WRAP_WORD = 32'hDDCCBBAA;
`else
    localparam logic [1:0]  WORD_FS0  = FS_ZEXT;
    localparam logic [1:0]  WORD_FSN  = FS_SHL;
    localparam logic [31:0] WRAP_WORD = 32'hAABBCCDD;
`endif

    dr_load_sequencer #(
        .ADDR_W  (16),
        .TIMEOUT (15)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Width     (Width),
        .SignExt   (SignExt),
        .BaseAddr  (BaseAddr),
        .MemReady  (MemReady),
        .MemRead   (MemRead),
        .MemAddr   (MemAddr),
        .DR_E      (DR_E),
        .DR_FunSel (DR_FunSel),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    assign MemData = mem[MemAddr];

    // Cycle counter used to time Done/Error pulses.
    always @(posedge Clock) cyc++;

    // Memory responder: holds MemReady low for the first stallCfg
    // cycles of each read burst, then answers every cycle.
    always @(posedge Clock) begin
        #1;
        if (MemRead) begin
            reqRun++;
            MemReady = (reqRun > stallCfg);
        end else begin
            reqRun = 0;
            MemReady = 1'b0;
        end
    end

    // Behavioural DataRegister fed from MemData.
    always @(posedge Clock) begin
        if (DR_E) begin
            case (DR_FunSel)
                2'b00:   drOut <= {{24{MemData[7]}}, MemData};
                2'b01:   drOut <= {24'h0, MemData};
                2'b10:   drOut <= {drOut[23:0], MemData};
                default: drOut <= {MemData, drOut[31:8]};
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic reportFail(input string name, input int actual);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=%0d required=none", name, actual);
    endtask

    // Monitor: compares every DUT output event against the scoreboard.
    always @(negedge Clock) begin
        expEvent_t e;
        if (MemRead) readCycles++;
        if (Reset_n) begin
            if (DR_E) begin
                if (expQ.size() == 0) begin
                    reportFail("unexpected_DR_E", 32'(MemAddr));
                end else begin
                    e = expQ.pop_front();
                    checkOutput("byte_kind", 32'(0), 32'(e.kind));
                    checkOutput("byte_addr", 32'(MemAddr), 32'(e.addr));
                    checkOutput("byte_funsel", 32'(DR_FunSel), 32'(e.fs));
                    checkOutput("byte_memread", 32'(MemRead), 32'(1));
                end
            end
            if (Done) begin
                if (expQ.size() == 0) begin
                    reportFail("unexpected_Done", cyc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("done_kind", 32'(1), 32'(e.kind));
                    checkOutput("done_cycle", 32'(cyc), 32'(e.cycle));
                    checkOutput("done_drout", drOut, e.value);
                    checkOutput("done_busy", 32'(Busy), 32'(1));
                end
            end
            if (Error) begin
                if (expQ.size() == 0) begin
                    reportFail("unexpected_Error", cyc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("error_kind", 32'(2), 32'(e.kind));
                    checkOutput("error_cycle", 32'(cyc), 32'(e.cycle));
                    checkOutput("error_memread", 32'(MemRead), 32'(0));
                end
            end
        end
    end

    task automatic pushByte(input logic [15:0] addr, input logic [1:0] fs);
        expQ.push_back('{kind: 0, addr: addr, fs: fs, value: 32'h0, cycle: 0});
    endtask

    task automatic pushDone(input int cycle, input logic [31:0] value);
        expQ.push_back('{kind: 1, addr: 16'h0, fs: 2'b00, value: value, cycle: cycle});
    endtask

    task automatic pushError(input int cycle);
        expQ.push_back('{kind: 2, addr: 16'h0, fs: 2'b00, value: 32'h0, cycle: cycle});
    endtask

    // Drives a Start request at the next falling edge; returns that cycle.
    task automatic applyStimulus(input logic [1:0] w, input logic s, input logic [15:0] base,
                                 input int stall, output int k);
        @(negedge Clock);
        stallCfg = stall;
        Width    = w;
        SignExt  = s;
        BaseAddr = base;
        Start    = 1'b1;
        k        = cyc;
    endtask

    task automatic endStimulus();
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic waitIdle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clock);
            if (expQ.size() == 0 && !Busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            reportFail("wait_idle_timeout", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_memread"}, 32'(MemRead), 32'(0));
        checkOutput({tag, "_memaddr"}, 32'(MemAddr), 32'(0));
        checkOutput({tag, "_dr_e"}, 32'(DR_E), 32'(0));
        checkOutput({tag, "_funsel"}, 32'(DR_FunSel), 32'(0));
        checkOutput({tag, "_busy"}, 32'(Busy), 32'(0));
        checkOutput({tag, "_done"}, 32'(Done), 32'(0));
        checkOutput({tag, "_error"}, 32'(Error), 32'(0));
    endtask

    initial begin
        int k;
        int k2;
        int r0;

        Start    = 1'b0;
        Width    = W_BYTE;
        SignExt  = 1'b0;
        BaseAddr = 16'h0;
        MemReady = 1'b0;
        Reset_n  = 1'b1;

`ifdef DRSEQ_LITTLE_ENDIAN_EN
        mem[16'h0100] = 8'h78; mem[16'h0101] = 8'h56; mem[16'h0102] = 8'h34; mem[16'h0103] = 8'h12;
        mem[16'h0200] = 8'h01; mem[16'h0201] = 8'h80;
`else
        mem[16'h0100] = 8'h12; mem[16'h0101] = 8'h34; mem[16'h0102] = 8'h56; mem[16'h0103] = 8'h78;
        mem[16'h0200] = 8'h80; mem[16'h0201] = 8'h01;
`endif
        mem[16'h0300] = 8'hF0;
        mem[16'hFFFF] = 8'hAA; mem[16'h0000] = 8'hBB; mem[16'h0001] = 8'hCC; mem[16'h0002] = 8'hDD;

        #1 Reset_n = 1'b0;
        repeat (3) @(negedge Clock);
        checkAllZero("reset");
        Reset_n = 1'b1;
        repeat (2) @(negedge Clock);

        // Word from 0x0100, memory always ready.
        applyStimulus(W_WORD, 1'b0, 16'h0100, 0, k);
`ifdef DRSEQ_LITTLE_ENDIAN_EN
        pushByte(16'h0100, WORD_FS0); pushByte(16'h0101, WORD_FSN);
        pushByte(16'h0102, WORD_FSN); pushByte(16'h0103, WORD_FSN);
`else
        pushByte(16'h0100, WORD_FS0); pushByte(16'h0101, WORD_FSN);
        pushByte(16'h0102, WORD_FSN); pushByte(16'h0103, WORD_FSN);
`endif
        pushDone(k + 5, 32'h12345678);
        endStimulus();
        waitIdle();

        // Halfword, signed then unsigned.
        applyStimulus(W_HALF, 1'b1, 16'h0200, 0, k);
`ifdef DRSEQ_LITTLE_ENDIAN_EN
        pushByte(16'h0201, FS_SEXT); pushByte(16'h0200, FS_SHL);
`else
        pushByte(16'h0200, FS_SEXT); pushByte(16'h0201, FS_SHL);
`endif
        pushDone(k + 3, 32'hFFFF8001);
        endStimulus();
        waitIdle();

        applyStimulus(W_HALF, 1'b0, 16'h0200, 0, k);
`ifdef DRSEQ_LITTLE_ENDIAN_EN
        pushByte(16'h0201, FS_ZEXT); pushByte(16'h0200, FS_SHL);
`else
        pushByte(16'h0200, FS_ZEXT); pushByte(16'h0201, FS_SHL);
`endif
        pushDone(k + 3, 32'h00008001);
        endStimulus();
        waitIdle();

        // Unsigned byte with three wait cycles.
        r0 = readCycles;
        applyStimulus(W_BYTE, 1'b0, 16'h0300, 3, k);
        pushByte(16'h0300, FS_ZEXT);
        pushDone(k + 5, 32'h000000F0);
        endStimulus();
        waitIdle();
        checkOutput("stall_read_cycles", 32'(readCycles - r0), 32'(4));

        // Signed byte.
        applyStimulus(W_BYTE, 1'b1, 16'h0300, 0, k);
        pushByte(16'h0300, FS_SEXT);
        pushDone(k + 2, 32'hFFFFFFF0);
        endStimulus();
        waitIdle();

        // Back-to-back: second Start issued in the first cycle after Done.
        applyStimulus(W_BYTE, 1'b0, 16'h0300, 0, k);
        pushByte(16'h0300, FS_ZEXT);
        pushDone(k + 2, 32'h000000F0);
        endStimulus();
        @(negedge Clock);
        applyStimulus(W_HALF, 1'b0, 16'h0200, 0, k2);
        checkOutput("b2b_start_cycle", 32'(k2), 32'(k + 3));
`ifdef DRSEQ_LITTLE_ENDIAN_EN
        pushByte(16'h0201, FS_ZEXT); pushByte(16'h0200, FS_SHL);
`else
        pushByte(16'h0200, FS_ZEXT); pushByte(16'h0201, FS_SHL);
`endif
        pushDone(k2 + 3, 32'h00008001);
        endStimulus();
        waitIdle();

        // Reserved width: immediate Error, no memory traffic.
        r0 = readCycles;
        applyStimulus(W_RSVD, 1'b0, 16'h0100, 0, k);
        pushError(k + 1);
        endStimulus();
        waitIdle();
        checkOutput("rsvd_read_cycles", 32'(readCycles - r0), 32'(0));

        // Memory never ready: timeout after 15 waiting cycles.
        r0 = readCycles;
        applyStimulus(W_WORD, 1'b0, 16'h0400, 1000, k);
        pushError(k + 16);
        endStimulus();
        waitIdle();
        checkOutput("timeout_read_cycles", 32'(readCycles - r0), 32'(15));

        // Address wrap from 0xFFFF.
        applyStimulus(W_WORD, 1'b0, 16'hFFFF, 0, k);
        pushByte(16'hFFFF, WORD_FS0); pushByte(16'h0000, WORD_FSN);
        pushByte(16'h0001, WORD_FSN); pushByte(16'h0002, WORD_FSN);
        pushDone(k + 5, WRAP_WORD);
        endStimulus();
        waitIdle();

        // Reset asserted after the second byte of a word load.
        applyStimulus(W_WORD, 1'b0, 16'hFFFF, 0, k);
        pushByte(16'hFFFF, WORD_FS0); pushByte(16'h0000, WORD_FSN);
        endStimulus();
        @(posedge Clock);
        @(posedge Clock);
        #3 Reset_n = 1'b0;
        #1;
        checkAllZero("midreset");
        checkOutput("midreset_queue", 32'(expQ.size()), 32'(0));
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        @(negedge Clock);

        // Normal load after the aborted one.
        applyStimulus(W_WORD, 1'b0, 16'h0100, 0, k);
        pushByte(16'h0100, WORD_FS0); pushByte(16'h0101, WORD_FSN);
        pushByte(16'h0102, WORD_FSN); pushByte(16'h0103, WORD_FSN);
        pushDone(k + 5, 32'h12345678);
        endStimulus();
        waitIdle();

        checkOutput("final_queue", 32'(expQ.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
